sudoku_group_sweeper: RTL and testbench

Bus-master sequencer that drives the register port of one nine-cell Sudoku group (row, column or box) through an external cell multiplexer. It reads every cell's solved value, builds the set of digits already placed, checks for duplicates, then writes the complementary mask into every cell's candidate register. It sits between the top-level solve controller (start/done handshake) and the per-group cell mux that routes `cell_sel` to nine cell instances.

---
 rtl/sudoku_pkg.sv | 17 +
 rtl/sudoku_onehot_check.sv | 13 +
 rtl/sudoku_group_sweeper.sv | 95 +++++++++
 tb/tb_sudoku_group_sweeper.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku group sweeper and its cell mux.
package sudoku_pkg;

    localparam int DIGIT_W = 9;
    localparam logic [DIGIT_W-1:0] ALL_DIGITS = 9'h1FF;

    localparam logic CELL_ADDR_VALUE = 1'b0;
    localparam logic CELL_ADDR_VALID = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ELIM = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sudoku_onehot_check.sv
// Combinational zero / one-hot classifier for a 9-bit digit mask.
module sudoku_onehot_check
    import sudoku_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic               is_zero,
    output logic               is_onehot
);

    assign is_zero   = (value == '0);
    assign is_onehot = !is_zero && ((value & (value - DIGIT_W'(1))) == '0);

endmodule

// File: rtl/sudoku_group_sweeper.sv
// Sweeps one Sudoku group: scan solved values, then write the complement mask to every cell.
// Optional feature macro: SUDOKU_SWEEP_CHANGED_EN enables the `changed` progress flag.
module sudoku_group_sweeper
    import sudoku_pkg::*;
#(
    parameter int N_CELLS = 9,
    parameter int SEL_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               conflict,
    output logic               changed,
    output logic [SEL_W-1:0]   cell_sel,
    output logic               cell_address,
    output logic               cell_we,
    output logic [DIGIT_W-1:0] cell_wdata,
    input  logic [DIGIT_W-1:0] cell_rdata
);

    sweep_state_t       state, state_nxt;
    logic [DIGIT_W-1:0] seen;
    logic               last_cell;
    logic               rd_zero, rd_onehot;
    logic               scan_conflict;

    sudoku_onehot_check u_check (
        .value     (cell_rdata),
        .is_zero   (rd_zero),
        .is_onehot (rd_onehot)
    );

    assign last_cell     = (cell_sel == SEL_W'(N_CELLS - 1));
    assign scan_conflict = (!rd_zero && !rd_onehot) || ((cell_rdata & seen) != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            // Conflict from the final cell must be folded in here, not read from the flag.
            SCAN: if (last_cell) state_nxt = (conflict || scan_conflict) ? DONE : ELIM;
            ELIM: if (last_cell) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen     <= '0;
            conflict <= 1'b0;
            cell_sel <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    seen     <= '0;
                    conflict <= 1'b0;
                    cell_sel <= '0;
                end
                SCAN: begin
                    seen <= seen | cell_rdata;
                    if (scan_conflict) conflict <= 1'b1;
                    cell_sel <= last_cell ? '0 : cell_sel + SEL_W'(1);
                end
                ELIM: cell_sel <= last_cell ? '0 : cell_sel + SEL_W'(1);
                default: ;
            endcase
        end
    end

`ifdef SUDOKU_SWEEP_CHANGED_EN
    // Read data during ELIM is the candidate mask before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (reset)                          changed <= 1'b0;
        else if (state == IDLE && start)    changed <= 1'b0;
        else if (state == ELIM && ((cell_rdata & seen) != '0)) changed <= 1'b1;
    end
`else
    assign changed = 1'b0;
`endif

    assign busy         = (state == SCAN) || (state == ELIM);
    assign done         = (state == DONE);
    assign cell_we      = (state == ELIM);
    assign cell_address = (state == ELIM) ? CELL_ADDR_VALID : CELL_ADDR_VALUE;
    assign cell_wdata   = (state == ELIM) ? (ALL_DIGITS & ~seen) : '0;

endmodule

// File: tb/tb_sudoku_group_sweeper.sv
// Directed bench: nine-cell group model behind the sweeper, assertion-checked per cycle.
module tb_sudoku_group_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, conflict, changed;
    logic [3:0] cell_sel;
    logic       cell_address, cell_we;
    logic [8:0] cell_wdata, cell_rdata;

    logic [8:0] val  [9];
    logic [8:0] cand [9];

    int n_cmp = 0;
    int n_err = 0;

`ifdef SUDOKU_SWEEP_CHANGED_EN
    localparam logic CHG_ON = 1'b1;
`else
    localparam logic CHG_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    sudoku_group_sweeper #(.N_CELLS(9), .SEL_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .changed      (changed),
        .cell_sel     (cell_sel),
        .cell_address (cell_address),
        .cell_we      (cell_we),
        .cell_wdata   (cell_wdata),
        .cell_rdata   (cell_rdata)
    );

    assign cell_rdata = (cell_sel < 4'd9) ? (cell_address ? cand[cell_sel] : val[cell_sel]) : 9'h000;

    always @(posedge clk)
        if (cell_we && cell_sel < 4'd9) cand[cell_sel] <= cell_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [8:0] v [9], input logic [8:0] c);
        for (int i = 0; i < 9; i++) begin
            val[i]  = v[i];
            cand[i] = c;
        end
    endtask

    // Start at edge 0, then check every cycle through one cycle past done.
    task automatic sweep(input int exp_done, input logic [8:0] exp_wdata,
                         input logic exp_conf, input logic exp_chg, input bit poke_start);
        logic exp_we;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            exp_we = !exp_conf && c >= 10 && c <= 18;
            check("busy", busy, c < exp_done);
            check("done", done, c == exp_done);
            check("cell_we", cell_we, exp_we);
            check("cell_address", cell_address, exp_we);
            if (exp_we) begin
                check("wdata", cell_wdata, exp_wdata);
                check("sel_elim", cell_sel, c - 10);
            end else begin
                check("wdata_idle", cell_wdata, 0);
            end
            if (c <= 9) check("sel_scan", cell_sel, c - 1);
            if (c >= exp_done) begin
                check("conflict", conflict, exp_conf);
                check("changed", changed, exp_chg);
            end
            if (c == exp_done && poke_start) start = 1'b1;
            if (c == exp_done + 1) start = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_conflict"}, conflict, 0);
        check({tag, "_changed"}, changed, 0);
        check({tag, "_sel"}, cell_sel, 0);
        check({tag, "_addr"}, cell_address, 0);
        check({tag, "_we"}, cell_we, 0);
        check({tag, "_wdata"}, cell_wdata, 0);
    endtask

    logic [8:0] g_basic [9] = '{9'h001, 9'h002, 9'h008, 0, 0, 0, 0, 0, 0};
    logic [8:0] g_dup   [9] = '{0, 0, 9'h010, 9'h001, 0, 0, 0, 9'h010, 0};
    logic [8:0] g_bad   [9] = '{9'h004, 0, 0, 9'h003, 0, 0, 0, 0, 0};
    logic [8:0] g_empty [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load(g_empty, 9'h1FF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Digits 1,2,4 placed; start poked during DONE must be ignored.
        load(g_basic, 9'h1FF);
        sweep(19, 9'h1F4, 1'b0, CHG_ON, 1'b1);
        for (int i = 0; i < 9; i++) check("cand_after", cand[i], 9'h1F4);

        // Same sweep immediately again: masks already pruned.
        sweep(19, 9'h1F4, 1'b0, 1'b0, 1'b0);

        load(g_dup, 9'h1FF);
        sweep(10, 9'h000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) check("cand_dup_untouched", cand[i], 9'h1FF);

        load(g_bad, 9'h1FF);
        sweep(10, 9'h000, 1'b1, 1'b0, 1'b0);

        load(g_empty, 9'h1FF);
        sweep(19, 9'h1FF, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 13 aborts mid-ELIM.
        load(g_basic, 9'h1FF);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 13; c++) @(negedge clk);
        check("we_before_reset", cell_we, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        check("cand_partial_written", cand[3], 9'h1F4);
        check("cand_partial_untouched", cand[4], 9'h1FF);
        reset = 1'b0;
        @(negedge clk);

        load(g_basic, 9'h1FF);
        sweep(19, 9'h1F4, 1'b0, CHG_ON, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
